// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: steers byte lanes onto a req/gnt/rvalid data bus,
// extends load results and holds the pipeline until the access completes or times out.
module mem_access_unit #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            funct3,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  stall,
   output logic                  done,
   output logic                  err,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [DM_ADDRESS-1:0] bus_addr,
   output logic [3:0]            bus_be,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic                  bus_gnt,
   input  logic                  bus_rvalid,
   input  logic [DATA_W-1:0]     bus_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  we_q, we_d;
   logic [DM_ADDRESS-1:0] baddr_q, baddr_d;
   logic [3:0]            be_q, be_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            off_q, off_d;
   logic [DATA_W-1:0]     rd_q, rd_d;
   logic                  timed_out;
   logic                  op_req;

   function automatic logic is_byte(input logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd4);
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return (f3 == 3'd1) || (f3 == 3'd5);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      if (is_half(f3))
         bad = off[0];
      else if (!is_byte(f3))
         bad = (off != 2'b00);
      return bad;
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      if (is_byte(f3))
         be = 4'b0001 << off;
      else if (is_half(f3))
         be = off[1] ? 4'b1100 : 4'b0011;
      else
         be = 4'b1111;
      return be;
   endfunction

   function automatic logic [DATA_W-1:0] store_steer(input logic [2:0] f3,
                                                     input logic [DATA_W-1:0] wd);
      logic [DATA_W-1:0] s;
      if (is_byte(f3))
         s = {4{wd[7:0]}};
      else if (is_half(f3))
         s = {2{wd[15:0]}};
      else
         s = wd;
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3,
                                                     input logic [1:0] off,
                                                     input logic [DATA_W-1:0] w);
      logic [7:0]        b;
      logic [15:0]       h;
      logic [DATA_W-1:0] r;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'd0:    r = {{24{b[7]}}, b};
         3'd4:    r = {24'b0, b};
         3'd1:    r = {{16{h[15]}}, h};
         3'd5:    r = {16'b0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   assign op_req    = mem_read || mem_write;
   assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      we_d    = we_q;
      baddr_d = baddr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rd_d    = rd_q;
      case (state_q)
         IDLE: begin
            err_d = 1'b0;
            if (op_req) begin
               rd_d = '0;
               if (misaligned(funct3, addr[1:0])) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
                  we_d    = mem_write;
                  baddr_d = {addr[DM_ADDRESS-1:2], 2'b00};
                  be_d    = mem_write ? byte_en(funct3, addr[1:0]) : 4'b1111;
                  wdata_d = store_steer(funct3, wr_data);
                  f3_d    = funct3;
                  off_d   = addr[1:0];
               end
            end
         end
         REQ: begin
            if (bus_gnt) begin
               state_d = we_q ? DONE : WAIT;
               cnt_d   = '0;
            end else if (timed_out) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT: begin
            if (bus_rvalid) begin
               state_d = DONE;
               rd_d    = load_extend(f3_q, off_q, bus_rdata);
            end else if (timed_out) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // control state: the only registers that need reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // bus fields and load result; outputs are gated by state so these stay unreset
   always_ff @(posedge clk) begin
      we_q    <= we_d;
      baddr_q <= baddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
   end

   assign stall     = ((state_q == IDLE) && op_req) || (state_q == REQ) || (state_q == WAIT);
   assign done      = (state_q == DONE);
   assign err       = done && err_q;
   assign rd_data   = done ? rd_q : '0;
   assign bus_req   = (state_q == REQ);
   assign bus_we    = bus_req && we_q;
   assign bus_addr  = bus_req ? baddr_q : '0;
   assign bus_be    = bus_req ? be_q : 4'b0000;
   assign bus_wdata = bus_req ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fixed vectors, randomized accesses against a
// behavioural model, and a reset-during-WAIT sequence.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [2:0]  funct3;
   logic [31:0] rd_data;
   logic        stall, done, err;
   logic        bus_req, bus_we;
   logic [8:0]  bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.DM_ADDRESS(9), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
      .wr_data(wr_data), .funct3(funct3),
      .rd_data(rd_data), .stall(stall), .done(done), .err(err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [8:0]  addr;
      logic [31:0] wd;
      logic [2:0]  f3;
      int          g;       // REQ cycles before gnt
      int          r;       // WAIT cycles before rvalid
      logic [31:0] rdata;
      logic        we;
      logic [8:0]  baddr;
      logic [3:0]  be;
      logic [31:0] bwd;
      logic [31:0] rdx;
      logic        err;
      int          stalls;
      int          reqc;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   // Reference model from the access rules: size/offset arithmetic on plain integers.
   function automatic vec_t model(input logic rd, input logic wr, input logic [8:0] a,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  input int g, input int r, input logic [31:0] rdata);
      vec_t v;
      int size, off;
      logic [31:0] mask, sh;
      v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.f3 = f3;
      v.g = g; v.r = r; v.rdata = rdata;
      off  = int'(a) % 4;
      size = (f3 == 0 || f3 == 4) ? 1 : ((f3 == 1 || f3 == 5) ? 2 : 4);
      v.we    = wr;
      v.baddr = a & 9'h1FC;
      v.be    = 4'b0000;
      for (int k = 0; k < 4; k++)
         if (k >= off && k < off + size) v.be[k] = 1'b1;
      if (!wr) v.be = 4'hF;
      v.bwd = (size == 1) ? wd[7:0] * 32'h01010101 :
              (size == 2) ? wd[15:0] * 32'h00010001 : wd;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      sh   = (rdata >> (8 * off)) & mask;
      if ((f3 == 0 || f3 == 1) && sh[8 * size - 1]) sh = sh | ~mask;
      v.rdx = 32'h0;
      if ((off % size) != 0) begin
         v.err = 1'b1; v.stalls = 1; v.reqc = 0;
      end else if (g >= TO) begin
         v.err = 1'b1; v.stalls = 1 + TO; v.reqc = TO;
      end else if (wr) begin
         v.err = 1'b0; v.stalls = 2 + g; v.reqc = g + 1;
      end else if (r >= TO) begin
         v.err = 1'b1; v.stalls = 2 + g + TO; v.reqc = g + 1;
      end else begin
         v.err = 1'b0; v.stalls = 3 + g + r; v.reqc = g + 1; v.rdx = sh;
      end
      return v;
   endfunction

   // Drives one access, plays the bus side, and checks the observed outcome.
   task automatic run_op(input vec_t v, input string nm);
      int   stalls  = 0;
      int   reqc    = 0;
      int   widx    = 0;
      bit   waiting = 1'b0;
      bit   seen    = 1'b0;
      bit   bus_ok  = 1'b1;
      logic got_err = 1'b0, got_stall = 1'b0, got_req = 1'b0;
      logic [31:0] got_rd = 32'h0;
      @(negedge clk);
      mem_read = v.rd; mem_write = v.wr; addr = v.addr; wr_data = v.wd; funct3 = v.f3;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         #1;
         if (done) begin
            seen = 1'b1;
            got_err = err; got_rd = rd_data; got_stall = stall; got_req = bus_req;
         end else begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (stall) stalls++;
            if (bus_req) begin
               if (bus_we !== v.we || bus_addr !== v.baddr || bus_be !== v.be ||
                   (v.we && bus_wdata !== v.bwd)) bus_ok = 1'b0;
               bus_gnt = (reqc == v.g);
               if (bus_gnt && !v.wr) waiting = 1'b1;
               reqc++;
               bus_rvalid = 1'($urandom_range(0, 1));
               bus_rdata  = $urandom;
            end else if (waiting) begin
               bus_rvalid = (widx == v.r);
               bus_rdata  = bus_rvalid ? v.rdata : $urandom;
               bus_gnt    = 1'($urandom_range(0, 1));
               widx++;
            end
            @(negedge clk);
         end
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0;
      chk({nm, " done seen"}, 32'(seen), 32'd1);
      chk({nm, " stall cycles"}, 32'(stalls), 32'(v.stalls));
      chk({nm, " req cycles"}, 32'(reqc), 32'(v.reqc));
      chk({nm, " bus fields"}, 32'(bus_ok), 32'd1);
      chk({nm, " err"}, 32'(got_err), 32'(v.err));
      chk({nm, " stall/req in done"}, {30'b0, got_stall, got_req}, 32'd0);
      if ((v.rd && !v.wr) || v.err) chk({nm, " rd_data"}, got_rd, v.rdx);
      @(negedge clk);
      #1;
      chk({nm, " after done"}, {29'b0, done, stall, bus_req}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wr_data = '0;
      funct3 = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

      //        rd wr addr    wd            f3 g  r  rdata          we baddr  be     bwd           rdx           err st rq
      vt[0]  = '{0, 1, 9'h010, 32'hDEADBEEF, 0+2, 0, 0, 32'h0,        1, 9'h010, 4'hF, 32'hDEADBEEF, 32'h0,        0, 2, 1};
      vt[1]  = '{0, 1, 9'h013, 32'h000000A5, 0,   0, 0, 32'h0,        1, 9'h010, 4'h8, 32'hA5A5A5A5, 32'h0,        0, 2, 1};
      vt[2]  = '{1, 0, 9'h012, 32'h0,        0,   0, 0, 32'h1280FF34, 0, 9'h010, 4'hF, 32'h0,        32'hFFFFFF80, 0, 3, 1};
      vt[3]  = '{1, 0, 9'h012, 32'h0,        5,   0, 0, 32'h1280FF34, 0, 9'h010, 4'hF, 32'h0,        32'h00001280, 0, 3, 1};
      vt[4]  = '{1, 0, 9'h011, 32'h0,        1,   0, 0, 32'h0,        0, 9'h000, 4'h0, 32'h0,        32'h0,        1, 1, 0};
      vt[5]  = '{1, 0, 9'h000, 32'h0,        2,  99, 0, 32'h0,        0, 9'h000, 4'hF, 32'h0,        32'h0,        1, 5, 4};
      vt[6]  = '{0, 1, 9'h016, 32'h0000BEEF, 1,   0, 0, 32'h0,        1, 9'h014, 4'hC, 32'hBEEFBEEF, 32'h0,        0, 2, 1};
      vt[7]  = '{1, 0, 9'h011, 32'h0,        4,   0, 0, 32'h1280FF34, 0, 9'h010, 4'hF, 32'h0,        32'h000000FF, 0, 3, 1};
      vt[8]  = '{1, 0, 9'h01C, 32'h0,        2,   1, 2, 32'h87654321, 0, 9'h01C, 4'hF, 32'h0,        32'h87654321, 0, 6, 2};
      vt[9]  = '{1, 0, 9'h004, 32'h0,        2,   0, 99, 32'h12345678, 0, 9'h004, 4'hF, 32'h0,       32'h0,        1, 6, 1};
      vt[10] = '{0, 1, 9'h012, 32'hCAFEF00D, 2,   0, 0, 32'h0,        1, 9'h000, 4'h0, 32'h0,        32'h0,        1, 1, 0};
      vt[11] = '{1, 0, 9'h004, 32'h0,        3,   0, 0, 32'h0BADF00D, 0, 9'h004, 4'hF, 32'h0,        32'h0BADF00D, 0, 3, 1};
      vt[12] = '{1, 1, 9'h008, 32'h11223344, 2,   0, 0, 32'h0,        1, 9'h008, 4'hF, 32'h11223344, 32'h0,        0, 2, 1};
      vt[13] = '{1, 0, 9'h01E, 32'h0,        1,   0, 0, 32'h80017FFF, 0, 9'h01C, 4'hF, 32'h0,        32'hFFFF8001, 0, 3, 1};

      repeat (3) @(negedge clk);
      bus_gnt = 1'b1; bus_rvalid = 1'b1;
      #1;
      chk("reset outputs", {27'b0, stall, done, err, bus_req, bus_we}, 32'd0);
      chk("reset rd_data", rd_data, 32'h0);
      chk("reset bus_wdata", bus_wdata, 32'h0);
      chk("reset bus_addr/be", {19'b0, bus_addr, bus_be}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("idle ignores gnt/rvalid", {29'b0, done, stall, bus_req}, 32'd0);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;

      for (int i = 0; i < 14; i++) run_op(vt[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 150; i++) begin
         int op;
         logic [2:0] f3s [8];
         vec_t v;
         f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
         op = int'($urandom_range(0, 2));
         v = model(op != 1, op != 0, 9'($urandom), $urandom, f3s[$urandom_range(0, 7)],
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom);
         run_op(v, $sformatf("rand%0d", i));
      end

      // reset while a load waits for rvalid; a late rvalid must be dropped
      @(negedge clk);
      mem_read = 1'b1; addr = 9'h020; funct3 = 3'd2;
      @(negedge clk);
      #1;
      chk("rst seq req", 32'(bus_req), 32'd1);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      #1;
      chk("rst seq in wait", {30'b0, stall, bus_req}, 32'd2);
      reset = 1'b1; mem_read = 1'b0;
      @(negedge clk);
      reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
      #1;
      chk("rst seq outputs", {28'b0, stall, done, err, bus_req}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rst seq late rvalid %0d", k), {28'b0, stall, done, err, bus_req}, 32'd0);
         chk($sformatf("rst seq rd_data %0d", k), rd_data, 32'h0);
      end
      bus_rvalid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
